// File: rtl/pair_pkg.sv
// Shared types and constants for the pair_detect serial front end.
package pair_pkg;

    // Serializer FSM states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Default parallel word width.
    localparam int unsigned PAIR_WORD_W = 5;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register with a full flag. Lets the next word wait while
// the current one is still shifting out.
module ser_hold_buf
    import pair_pkg::*;
#(
    parameter int unsigned WIDTH = PAIR_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    // Capture on write, release on read; reset discards any held word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (write) begin
            data_q <= data_in;
            full_q <= 1'b1;
        end else if (read) begin
            full_q <= 1'b0;
        end
    end

    assign data_out = data_q;
    assign full     = full_q;

endmodule

// File: rtl/pair_bit_serializer.sv
// Parallel-to-serial front end for pair_detect. Words arrive over valid/ready
// and leave one bit per clock; a one-word hold buffer keeps frames gapless.
module pair_bit_serializer
    import pair_pkg::*;
#(
    parameter int unsigned WIDTH      = PAIR_WORD_W,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             inbits,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             inbits_q, inbits_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;

    logic             hold_wr, hold_rd, hold_full, hold_full_d;
    logic [WIDTH-1:0] hold_data;
    logic             xfer, load_word;
    logic [WIDTH-1:0] word;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Remaining bits after the first is presented, next bit always at the exit end.
    function automatic logic [WIDTH-1:0] rest_bits(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign load_ready = reset & ~hold_full;
    assign xfer       = load_valid & load_ready;

    ser_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .write   (hold_wr),
        .read    (hold_rd),
        .data_in (d),
        .data_out(hold_data),
        .full    (hold_full)
    );

    // Next-state: shift the current word, then drain hold or take d directly.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        inbits_d      = inbits_q;
        bit_valid_d   = bit_valid_q;
        frame_start_d = 1'b0;
        hold_wr       = 1'b0;
        hold_rd       = 1'b0;
        load_word     = 1'b0;
        word          = d;

        unique case (state_q)
            IDLE: begin
                load_word = xfer;
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    inbits_d = first_bit(shreg_q);
                    shreg_d  = rest_bits(shreg_q);
                    cnt_d    = cnt_q - CntW'(1);
                    hold_wr  = xfer;
                end else if (hold_full) begin
                    load_word = 1'b1;
                    word      = hold_data;
                    hold_rd   = 1'b1;
                end else if (xfer) begin
                    load_word = 1'b1;
                end else begin
                    state_d     = IDLE;
                    bit_valid_d = 1'b0;
                    inbits_d    = IDLE_LEVEL;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_word) begin
            inbits_d      = first_bit(word);
            shreg_d       = rest_bits(word);
            cnt_d         = CntLast;
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            state_d       = SHIFT;
        end

        hold_full_d = hold_wr ? 1'b1 : (hold_rd ? 1'b0 : hold_full);
        busy_d      = (state_d == SHIFT) | hold_full_d;
    end

    // State and registered serial outputs; reset wins over any transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            inbits_q      <= IDLE_LEVEL;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            inbits_q      <= inbits_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign inbits      = inbits_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pair_bit_serializer.sv
// Directed bench for pair_bit_serializer: one MSB-first and one LSB-first
// instance, serial output checked against a queue of expected bits.
module tb_pair_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_a, d_b;
    logic       lv_a, lv_b;
    logic       lr_a, lr_b;
    logic       ib_a, ib_b;
    logic       bv_a, bv_b;
    logic       fs_a, fs_b;
    logic       busy_a, busy_b;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] q_a[$];  // {bit, frame_start}
    logic [1:0] q_b[$];

    always #5 clk = ~clk;

    pair_bit_serializer #(
        .WIDTH(5), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .d(d_a), .load_valid(lv_a), .load_ready(lr_a),
        .inbits(ib_a), .bit_valid(bv_a), .frame_start(fs_a), .busy(busy_a)
    );

    pair_bit_serializer #(
        .WIDTH(5), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .d(d_b), .load_valid(lv_b), .load_ready(lr_b),
        .inbits(ib_b), .bit_valid(bv_b), .frame_start(fs_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input bit sel, input logic [4:0] w);
        int idx;
        for (int i = 0; i < 5; i++) begin
            idx = sel ? i : 4 - i;
            if (sel) q_b.push_back({w[idx], (i == 0)});
            else     q_a.push_back({w[idx], (i == 0)});
        end
    endtask

    // Offer one word for a single cycle; it must be accepted at that edge.
    task automatic offer(input bit sel, input logic [4:0] w);
        if (sel) begin
            d_b = w; lv_b = 1'b1;
            check("b_ready_offer", lr_b, 1);
        end else begin
            d_a = w; lv_a = 1'b1;
            check("a_ready_offer", lr_a, 1);
        end
        push_word(sel, w);
        step();
        lv_a = 1'b0;
        lv_b = 1'b0;
    endtask

    // Serial output monitors, sampled mid-cycle.
    always @(negedge clk) begin
        logic [1:0] e;
        if (bv_a === 1'b1) begin
            if (q_a.size() == 0) check("a_unexpected_bit", bv_a, 0);
            else begin
                e = q_a.pop_front();
                check("a_bit", ib_a, e[1]);
                check("a_frame_start", fs_a, e[0]);
            end
        end else if (bv_a === 1'b0) begin
            check("a_fs_when_idle", fs_a, 0);
        end
        if (bv_b === 1'b1) begin
            if (q_b.size() == 0) check("b_unexpected_bit", bv_b, 0);
            else begin
                e = q_b.pop_front();
                check("b_bit", ib_b, e[1]);
                check("b_frame_start", fs_b, e[0]);
            end
        end else if (bv_b === 1'b0) begin
            check("b_fs_when_idle", fs_b, 0);
        end
    end

    initial begin
        // Reset held for two edges with a word on offer.
        reset = 1'b0; lv_a = 1'b1; d_a = 5'b11111; lv_b = 1'b0; d_b = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("a_ready_in_reset", lr_a, 0);
        check("a_inbits_in_reset", ib_a, 0);
        check("a_valid_in_reset", bv_a, 0);
        check("a_busy_in_reset", busy_a, 0);
        check("b_ready_in_reset", lr_b, 0);
        reset = 1'b1; lv_a = 1'b0;
        #1;
        check("a_ready_after_reset", lr_a, 1);
        check("b_ready_after_reset", lr_b, 1);
        step();
        check("a_no_word_from_reset", bv_a, 0);

        // Single word from idle.
        offer(1'b0, 5'b10110);
        repeat (4) step();
        check("a_busy_last_bit", busy_a, 1);
        step();
        check("a_single_done_valid", bv_a, 0);
        check("a_single_done_inbits", ib_a, 0);
        check("a_single_done_busy", busy_a, 0);
        check("a_single_queue_left", q_a.size(), 0);

        // Back-to-back words plus a third offered while hold is full.
        d_a = 5'b11111; lv_a = 1'b1;
        check("a_ready_w1", lr_a, 1);
        push_word(1'b0, d_a);
        step();
        d_a = 5'b00001;
        check("a_ready_w2", lr_a, 1);
        push_word(1'b0, d_a);
        step();
        d_a = 5'b01010;
        for (int i = 0; i < 4; i++) begin
            check("a_ready_hold_full", lr_a, 0);
            check("a_busy_hold_full", busy_a, 1);
            step();
        end
        check("a_ready_after_drain", lr_a, 1);
        push_word(1'b0, d_a);
        step();
        lv_a = 1'b0;
        repeat (9) step();
        check("a_stream_done_valid", bv_a, 0);
        check("a_stream_done_busy", busy_a, 0);
        check("a_stream_queue_left", q_a.size(), 0);

        // Reset mid-frame with a word sitting in hold.
        offer(1'b0, 5'b10110);
        d_a = 5'b11000; lv_a = 1'b1;
        check("a_ready_hold_wr", lr_a, 1);
        step();
        lv_a = 1'b0; reset = 1'b0;
        #1;
        check("a_ready_reset_low", lr_a, 0);
        step();
        q_a.delete();
        check("a_midreset_valid", bv_a, 0);
        check("a_midreset_inbits", ib_a, 0);
        check("a_midreset_busy", busy_a, 0);
        reset = 1'b1;
        step();
        check("a_after_midreset_valid", bv_a, 0);
        offer(1'b0, 5'b00111);
        repeat (5) step();
        check("a_post_reset_done", bv_a, 0);
        check("a_post_reset_busy", busy_a, 0);
        check("a_post_reset_queue", q_a.size(), 0);

        // LSB-first instance.
        offer(1'b1, 5'b10110);
        repeat (5) step();
        check("b_done_valid", bv_b, 0);
        check("b_done_inbits", ib_b, 0);
        check("b_done_busy", busy_b, 0);
        check("b_queue_left", q_b.size(), 0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pair_bit_serializer.md
Name: pair_bit_serializer

Overview:
Parallel-to-serial front end that feeds the pair_detect stage. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on inbits, which drives pair_detect's serial input directly. A one-entry holding buffer allows back-to-back words to stream with no idle gap.

Parameters:
WIDTH, 5, word width in bits (>=2)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
IDLE_LEVEL, 0, value driven on inbits when no bit is valid

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (0 at posedge = reset)
d  input  WIDTH  parallel word to serialize
load_valid  input  1  d is valid this cycle
load_ready  output  1  block can accept d this cycle
inbits  output  1  serial bit to pair_detect, registered
bit_valid  output  1  inbits carries a data bit this cycle, registered
frame_start  output  1  high with the first bit of each word, registered
busy  output  1  state is SHIFT or holding buffer is full

Behaviour:
- Transfer occurs at a posedge where load_valid & load_ready.
- load_ready = reset & ~hold_full (combinational). It is 0 while reset is low.
- Reset (reset==0 at posedge): state=IDLE, shift reg=0, bit counter=0, hold buffer emptied and discarded. Outputs: inbits=IDLE_LEVEL, bit_valid=0, frame_start=0, busy=0. Reset overrides any simultaneous transfer; a word offered during reset is not taken.
- FSM states: IDLE, SHIFT.
- IDLE:
  - A transfer loads d directly into the shift register (the hold buffer is bypassed).
  - Same edge: inbits<=first bit, bit_valid<=1, frame_start<=1, counter<=WIDTH-1, state<=SHIFT.
  - Latency: first bit visible one clock after acceptance.
- SHIFT, counter>0:
  - Next bit is presented, counter decrements, frame_start<=0.
  - A transfer in this state writes the hold buffer.
- SHIFT, counter==0 (last bit currently on output), at next edge:
  - Hold full: load the hold word, present its first bit with frame_start=1, hold becomes empty, stay in SHIFT.
  - Hold empty and transfer this edge: load d directly as above (gapless).
  - Otherwise: state<=IDLE, bit_valid<=0, inbits<=IDLE_LEVEL.
- A transfer coinciding with a hold drain cannot occur, because load_ready=0 while hold is full.
- Bit order: MSB_FIRST=1 gives d[WIDTH-1]..d[0]; MSB_FIRST=0 gives d[0]..d[WIDTH-1].
- Each accepted word yields exactly WIDTH consecutive bit_valid cycles. Words are never dropped, duplicated or reordered.
- Counter width: $clog2(WIDTH); the counter never wraps past 0.
- busy is registered and mirrors (state==SHIFT) | hold_full.

Decomposition:
- Shared package pair_pkg: state enum {IDLE, SHIFT}; default word width constant PAIR_WORD_W=5.
- One sub-module, ser_hold_buf: one-entry WIDTH-bit register with full flag. Interface: write, read, data_out, full.
- FSM, shift register and counter stay in the top module.

Test Plan:
- Reset low for 2 edges with load_valid=1 -> load_ready=0, inbits=0, bit_valid=0, no word taken. Reset high -> load_ready=1.
- Single 5'b10110 accepted in IDLE -> next 5 cycles inbits=1,0,1,1,0 with bit_valid=1 and frame_start only on the first. Cycle 6: bit_valid=0, inbits=0, busy=0.
- load_valid held high with 5'b11111 then 5'b00001 -> 10 consecutive bit_valid cycles, bits 1,1,1,1,1,0,0,0,0,1, frame_start at cycles 1 and 6.
- Third word 5'b01010 offered while hold full -> load_ready=0 until hold drains at the frame boundary. Word accepted the next cycle, bits follow with no corruption of the second word.
- reset=0 after 2 bits of 5'b10110 -> next edge: bit_valid=0, inbits=0, hold empty. New word 5'b00111 afterwards serializes as 0,0,1,1,1 from frame_start.
- MSB_FIRST=0, 5'b10110 -> inbits=0,1,1,0,1.
